glb_wrport_packer: RTL and testbench

Upstream feeder for one GLB write port. It accepts a narrow input stream of IN_WIDTH-bit beats and packs them into full write-port lines of SRAM_WIDTH*MAXPAR bits, filling only the runtime-configured number of parallel banks. It drives the GLB's WrPortDat/WrPortDatVld/WrPortDatLast and obeys WrPortDatRdy. A pack register and a one-deep output register let packing of line n+1 overlap the GLB stall on line n.

---
 rtl/glb_wrport_packer.sv | 187 ++++++++++++++++++
 tb/tb_glb_wrport_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_wrport_packer.sv
// Purpose : packs a narrow IN_WIDTH beat stream into SRAM_WIDTH*MAXPAR write-port
//           lines for one GLB write port, filling only the configured bank count.
// Latency : closing beat accepted at t -> WrPortDatVld at t+1; last line handshake at t -> Done at t+1.
// Backpr. : non-closing beats always pack; only a closing beat stalls, and only while
//           the output register holds an unaccepted line (WrPortDatVld & !WrPortDatRdy).
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   CfgVld/CfgRdy/CfgParBank/CfgNumLine session configuration (accepted in IDLE only)
//   InDat/InDatVld/InDatLast/InDatRdy  input beat stream
//   WrPortDat/Vld/Last, WrPortDatRdy   packed line towards the GLB
//   LineCnt                            lines handshaken to the GLB this session
//   Done                               one-cycle session-complete pulse
module glb_wrport_packer #(
  parameter int IN_WIDTH   = 128,
  parameter int SRAM_WIDTH = 256,
  parameter int MAXPAR     = 4,
  parameter int ADDR_WIDTH = 16,
  localparam int RATIO     = SRAM_WIDTH / IN_WIDTH,
  localparam int PAR_W     = $clog2(MAXPAR) + 1,
  localparam int OUT_WIDTH = SRAM_WIDTH * MAXPAR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CfgVld,
  output logic                  CfgRdy,
  input  logic [PAR_W-1:0]      CfgParBank,
  input  logic [ADDR_WIDTH-1:0] CfgNumLine,
  input  logic [IN_WIDTH-1:0]   InDat,
  input  logic                  InDatVld,
  input  logic                  InDatLast,
  output logic                  InDatRdy,
  output logic [OUT_WIDTH-1:0]  WrPortDat,
  output logic                  WrPortDatVld,
  output logic                  WrPortDatLast,
  input  logic                  WrPortDatRdy,
  output logic [ADDR_WIDTH-1:0] LineCnt,
  output logic                  Done
);

  localparam int BEATS_MAX = MAXPAR * RATIO;
  localparam int BEAT_W    = $clog2(BEATS_MAX + 1);
  localparam logic [BEAT_W-1:0] RATIO_B = BEAT_W'(RATIO);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [PAR_W-1:0]      par_q, par_d;
  logic [ADDR_WIDTH-1:0] num_line_q, num_line_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [OUT_WIDTH-1:0]  pack_q, pack_d;
  logic [OUT_WIDTH-1:0]  dat_q, dat_d;
  logic                  vld_q, vld_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] line_out_q, line_out_d;
  logic                  done_q, done_d;

  logic [BEAT_W-1:0]     beats_per_line;
  logic                  closing;
  logic                  line_last;
  logic                  out_hs;
  logic                  beat_acc;
  logic [OUT_WIDTH-1:0]  pack_wr;

  assign WrPortDat     = dat_q;
  assign WrPortDatVld  = vld_q;
  assign WrPortDatLast = last_q;
  assign LineCnt       = line_out_q;
  assign Done          = done_q;

  always_comb begin
    state_d    = state_q;
    par_d      = par_q;
    num_line_d = num_line_q;
    beat_cnt_d = beat_cnt_q;
    line_cnt_d = line_cnt_q;
    pack_d     = pack_q;
    dat_d      = dat_q;
    vld_d      = vld_q;
    last_d     = last_q;
    line_out_d = line_out_q;
    done_d     = 1'b0;

    CfgRdy         = (state_q == S_IDLE);
    beats_per_line = BEAT_W'(par_q) * RATIO_B;
    closing        = (beat_cnt_q == beats_per_line - BEAT_W'(1)) || InDatLast;
    line_last      = (line_cnt_q == num_line_q - ADDR_WIDTH'(1)) || InDatLast;
    out_hs         = vld_q && WrPortDatRdy;
    // Only a closing beat needs the output register; it may close in the same
    // cycle the held line leaves, which keeps back-to-back lines bubble-free.
    InDatRdy       = (state_q == S_PACK) && !(closing && vld_q && !WrPortDatRdy);
    beat_acc       = InDatVld && InDatRdy;

    // Pack register with the incoming beat merged in at its slot.
    pack_wr = pack_q;
    for (int b = 0; b < BEATS_MAX; b++) begin
      if (beat_cnt_q == BEAT_W'(b)) begin
        pack_wr[b*IN_WIDTH +: IN_WIDTH] = InDat;
      end
    end

    if (out_hs) begin
      vld_d      = 1'b0;
      last_d     = 1'b0;
      line_out_d = line_out_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (CfgVld) begin
          if (CfgParBank == '0) begin
            par_d = PAR_W'(1);
          end else if (CfgParBank > PAR_W'(MAXPAR)) begin
            par_d = PAR_W'(MAXPAR);
          end else begin
            par_d = CfgParBank;
          end
          num_line_d = CfgNumLine;
          beat_cnt_d = '0;
          line_cnt_d = '0;
          line_out_d = '0;
          pack_d     = '0;
          if (CfgNumLine == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_PACK;
          end
        end
      end
      S_PACK: begin
        if (beat_acc) begin
          if (closing) begin
            dat_d      = pack_wr;
            vld_d      = 1'b1;
            last_d     = line_last;
            line_cnt_d = line_cnt_q + ADDR_WIDTH'(1);
            beat_cnt_d = '0;
            pack_d     = '0;
            if (line_last) begin
              state_d = S_DRAIN;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            pack_d     = pack_wr;
          end
        end
      end
      S_DRAIN: begin
        if (out_hs && last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      par_q      <= PAR_W'(1);
      num_line_q <= '0;
      beat_cnt_q <= '0;
      line_cnt_q <= '0;
      pack_q     <= '0;
      dat_q      <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      line_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_q      <= par_d;
      num_line_q <= num_line_d;
      beat_cnt_q <= beat_cnt_d;
      line_cnt_q <= line_cnt_d;
      pack_q     <= pack_d;
      dat_q      <= dat_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      line_out_q <= line_out_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_glb_wrport_packer.sv
// Purpose : bench for glb_wrport_packer with a beat-list reference model and a
//           queue scoreboard; stimulus side predicts lines, output monitor checks them.
// Latency : n/a.  Backpr. : bench drives random, scripted and stalled WrPortDatRdy.
module tb_glb_wrport_packer;

  localparam int IN_W  = 128;
  localparam int OUT_W = 1024;
  localparam int RATIO = 2;

  logic              clk;
  logic              rst_n;
  logic              CfgVld;
  logic              CfgRdy;
  logic [2:0]        CfgParBank;
  logic [15:0]       CfgNumLine;
  logic [IN_W-1:0]   InDat;
  logic              InDatVld;
  logic              InDatLast;
  logic              InDatRdy;
  logic [OUT_W-1:0]  WrPortDat;
  logic              WrPortDatVld;
  logic              WrPortDatLast;
  logic              WrPortDatRdy;
  logic [15:0]       LineCnt;
  logic              Done;

  glb_wrport_packer dut (
    .clk(clk), .rst_n(rst_n),
    .CfgVld(CfgVld), .CfgRdy(CfgRdy), .CfgParBank(CfgParBank), .CfgNumLine(CfgNumLine),
    .InDat(InDat), .InDatVld(InDatVld), .InDatLast(InDatLast), .InDatRdy(InDatRdy),
    .WrPortDat(WrPortDat), .WrPortDatVld(WrPortDatVld), .WrPortDatLast(WrPortDatLast),
    .WrPortDatRdy(WrPortDatRdy), .LineCnt(LineCnt), .Done(Done)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_cyc_cfg  = -1;
  int done_cyc_last = -1;

  logic [OUT_W-1:0] exp_dat_q[$];
  bit               exp_last_q[$];
  int               hs_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_dat(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    bit shown;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      shown = 1'b0;
      for (int k = 0; k < OUT_W / IN_W; k++) begin
        if (!shown && act[k*IN_W +: IN_W] !== exp[k*IN_W +: IN_W]) begin
          $display("FAIL %s slice %0d got %h required %h (cycle %0d)", nm, k,
                   act[k*IN_W +: IN_W], exp[k*IN_W +: IN_W], cyc);
          shown = 1'b1;
        end
      end
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_cfgrdy", CfgRdy, 1);
    chk("rst_indatrdy", InDatRdy, 0);
    chk("rst_vld", WrPortDatVld, 0);
    chk("rst_last", WrPortDatLast, 0);
    chk_dat("rst_dat", WrPortDat, '0);
    chk("rst_linecnt", LineCnt, 0);
    chk("rst_done", Done, 0);
  endtask

  // Reference model: collect accepted beats of the current line in a list; a line
  // is complete after ParBank*RATIO beats or on InDatLast, and is laid out beat 0 at
  // the bottom with everything above the collected beats zero.
  initial begin : in_mon
    logic [IN_W-1:0]  beats[$];
    logic [OUT_W-1:0] line;
    int par_e;
    int nl;
    int lines;
    par_e = 1; nl = 0; lines = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beats.delete();
        lines = 0;
        done_cyc_cfg = -1;
      end else begin
        if (CfgVld && CfgRdy) begin
          par_e = (CfgParBank == 0) ? 1 : (CfgParBank > 4) ? 4 : int'(CfgParBank);
          nl    = int'(CfgNumLine);
          lines = 0;
          beats.delete();
          if (nl == 0) done_cyc_cfg = cyc + 1;
        end
        if (InDatVld && InDatRdy) begin
          beats.push_back(InDat);
          if (beats.size() == par_e * RATIO || InDatLast) begin
            line = '0;
            foreach (beats[i]) line[i*IN_W +: IN_W] = beats[i];
            exp_dat_q.push_back(line);
            exp_last_q.push_back((lines == nl - 1) || InDatLast);
            lines++;
            beats.delete();
          end
        end
      end
    end
  end

  initial begin : out_mon
    logic [OUT_W-1:0] hold_dat;
    logic [OUT_W-1:0] e_dat;
    bit   hold_last;
    bit   stalled;
    bit   e_last;
    bit   exp_done;
    int   lc;
    stalled = 1'b0; lc = 0; hold_dat = '0; hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_dat_q.delete();
        exp_last_q.delete();
        lc = 0;
        stalled = 1'b0;
        done_cyc_last = -1;
      end else begin
        exp_done = (cyc == done_cyc_last) || (cyc == done_cyc_cfg);
        if (Done || exp_done) begin
          chk("done_pulse", Done, exp_done);
          chk("linecnt_at_done", LineCnt, lc);
        end
        if (stalled) begin
          chk("hold_vld", WrPortDatVld, 1);
          chk_dat("hold_dat", WrPortDat, hold_dat);
          chk("hold_last", WrPortDatLast, hold_last);
        end
        if (WrPortDatVld && WrPortDatRdy) begin
          if (exp_dat_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_line got WrPortDatVld=1 required no pending line (cycle %0d)", cyc);
          end else begin
            e_dat  = exp_dat_q.pop_front();
            e_last = exp_last_q.pop_front();
            chk_dat("line_dat", WrPortDat, e_dat);
            chk("line_last", WrPortDatLast, e_last);
            chk("linecnt_at_hs", LineCnt, lc);
            lc++;
            hs_q.push_back(cyc);
            if (e_last) done_cyc_last = cyc + 1;
          end
        end
        stalled   = WrPortDatVld && !WrPortDatRdy;
        hold_dat  = WrPortDat;
        hold_last = WrPortDatLast;
        if (CfgVld && CfgRdy) lc = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic run_session(input int par, input int nl, input int last_idx, input int vld_pct,
                             input int rdy_pct, input bit stall, input int rst_after,
                             input int exp_lines);
    int idx;
    int cycles;
    int vld_seen;
    bit done;
    bit acc;
    idx = 0; cycles = 0; vld_seen = 0; done = 1'b0;
    CfgVld = 1'b1;
    CfgParBank = 3'(par);
    CfgNumLine = 16'(nl);
    WrPortDatRdy = 1'b1;
    @(negedge clk);
    chk("cfg_rdy", CfgRdy, 1);
    @(posedge clk); #1;
    CfgVld = 1'b0;
    while (!done && cycles < 3000) begin
      if (!InDatVld && ($urandom_range(99) < 32'(vld_pct))) begin
        InDatVld  = 1'b1;
        InDat     = {$urandom, $urandom, $urandom, 32'(idx)};
        InDatLast = (idx == last_idx);
      end
      if (stall) WrPortDatRdy = (vld_seen >= 10);
      else       WrPortDatRdy = ($urandom_range(99) < 32'(rdy_pct));
      @(negedge clk);
      cycles++;
      acc = InDatVld && InDatRdy;
      if (acc) idx++;
      if (Done) done = 1'b1;
      if (stall && WrPortDatVld && !WrPortDatRdy) begin
        vld_seen++;
        if (vld_seen == 10) chk("stall_beats_accepted", 64'(idx), 7);
      end
      if (rst_after >= 0 && idx == rst_after) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        InDatVld = 1'b0;
        InDatLast = 1'b0;
        #1;
        chk_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      if (acc) begin
        InDatVld  = 1'b0;
        InDatLast = 1'b0;
      end
    end
    chk("session_done", done, 1);
    chk("cfg_rdy_after", CfgRdy, 1);
    chk("no_pending_lines", 64'(exp_dat_q.size()), 0);
    if (exp_lines >= 0) chk("linecnt_final", LineCnt, 64'(exp_lines));
    InDatVld  = 1'b0;
    InDatLast = 1'b0;
  endtask

  initial begin : main
    rst_n = 1'b0;
    CfgVld = 1'b0; CfgParBank = '0; CfgNumLine = '0;
    InDat = '0; InDatVld = 1'b0; InDatLast = 1'b0; WrPortDatRdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full-throughput session: three lines four cycles apart.
    hs_q.delete();
    run_session(2, 3, -1, 100, 100, 1'b0, -1, 3);
    chk("tput_lines", 64'(hs_q.size()), 3);
    for (int i = 1; i < hs_q.size(); i++) chk("tput_spacing", 64'(hs_q[i] - hs_q[i-1]), 4);

    // Output stalled for 10 cycles after line0 is valid.
    run_session(2, 3, -1, 100, 100, 1'b1, -1, 3);

    // Early InDatLast on the 3rd beat of line1.
    run_session(4, 5, 10, 100, 100, 1'b0, -1, 2);

    // Empty session.
    run_session(1, 0, -1, 100, 100, 1'b0, -1, 0);

    // ParBank out of range: 0 -> 1, 7 -> 4.
    run_session(0, 2, -1, 100, 100, 1'b0, -1, 2);
    run_session(7, 2, -1, 100, 100, 1'b0, -1, 2);

    // Reset in the middle of line1, then a clean one-line session.
    run_session(2, 3, -1, 100, 100, 1'b0, 6, -1);
    run_session(1, 1, -1, 100, 100, 1'b0, -1, 1);

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      run_session(int'($urandom_range(7)), int'($urandom_range(1, 4)),
                  ($urandom_range(1) == 0) ? -1 : int'($urandom_range(20)),
                  int'($urandom_range(40, 100)), int'($urandom_range(30, 100)),
                  1'b0, -1, -1);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
